// File: rtl/rs_pkg.sv
// Shared types and constants for the ALU reservation station.
package rs_pkg;

  localparam int RS_TAG_W = 6;
  localparam int RS_ROB_W = 6;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  // Width-independent operation fields carried by every entry.
  typedef struct packed {
    logic [3:0]  alu_control;
    logic        alu_src;
    logic        is_for_lsq;
    logic [31:0] imm;
  } rs_op_t;

endpackage

// File: rtl/rs_select.sv
// Issue selector: one-hot grant among ready entries.
// RESERVATION_STATION_OLDEST_FIRST_EN: lowest age rank wins; otherwise lowest index wins.
module rs_select
  import rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]                    ready,
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][$clog2(DEPTH)-1:0] rank,
`endif
  output logic [DEPTH-1:0]                    grant,
  output logic                                grant_valid
);

  assign grant_valid = |ready;

`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
  // Ranks are unique among valid entries, so exactly one ready entry survives.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && rank[j] < rank[i]) grant[i] = 1'b0;
      end
    end
  end
`else
  assign grant = ready & (~ready + DEPTH'(1));
`endif

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched ops, snoops wakeups, issues one ready op per cycle.
// RESERVATION_STATION_OLDEST_FIRST_EN selects oldest-first issue; default is lowest-index issue.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = RS_TAG_W,
  parameter int ROB_W = RS_ROB_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [3:0]               disp_alu_control,
  input  logic                     disp_alu_src,
  input  logic                     disp_is_for_lsq,
  input  logic [31:0]              disp_imm,
  input  logic                     disp_rs1_ready,
  input  logic                     disp_rs2_ready,
  input  logic [TAG_W-1:0]         disp_rs1_tag,
  input  logic [TAG_W-1:0]         disp_rs2_tag,
  input  logic [31:0]              disp_rs1_value,
  input  logic [31:0]              disp_rs2_value,
  input  logic [TAG_W-1:0]         disp_dest_tag,
  input  logic [ROB_W-1:0]         disp_rob_index,
  input  logic                     wakeup_active,
  input  logic [TAG_W-1:0]         wakeup_tag,
  input  logic [31:0]              wakeup_value,
  input  logic                     fu_is_available,
  output logic                     issue_write_enable,
  output logic [3:0]               issue_alu_control,
  output logic                     issue_alu_src,
  output logic                     issue_is_for_lsq,
  output logic [31:0]              issue_imm,
  output logic [31:0]              issue_rs1_value,
  output logic [31:0]              issue_rs2_value,
  output logic [TAG_W-1:0]         issue_tag_to_output,
  output logic [ROB_W-1:0]         issue_rob_index,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    rs_op_t           op;
    logic             rs1_ready;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_value;
    logic             rs2_ready;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_value;
    logic [TAG_W-1:0] dest_tag;
    logic [ROB_W-1:0] rob_index;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [DEPTH-1:0]   ready_vec, grant;
  logic               grant_valid, issue_fire, disp_fire;
  logic               rs1_match, rs2_match;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  entry_t             disp_ent;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
  logic [DEPTH-1:0][IDX_W-1:0] rank_q, rank_d;
  logic [IDX_W-1:0]            issue_rank;
`endif

  assign disp_ready         = occ_q < FULL;
  assign occupancy          = occ_q;
  assign issue_fire         = fu_is_available && grant_valid;
  assign issue_write_enable = issue_fire;
  assign disp_fire          = disp_valid && disp_ready && !flush;

  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      ready_vec[i] = ent_q[i].valid && ent_q[i].rs1_ready && ent_q[i].rs2_ready;
  end

  rs_select #(.DEPTH(DEPTH)) u_select (
    .ready       (ready_vec),
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
    .rank        (rank_q),
`endif
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Fields stay zero when no entry is granted, which also covers the reset state.
  always_comb begin
    issue_idx           = '0;
    issue_alu_control   = '0;
    issue_alu_src       = 1'b0;
    issue_is_for_lsq    = 1'b0;
    issue_imm           = '0;
    issue_rs1_value     = '0;
    issue_rs2_value     = '0;
    issue_tag_to_output = '0;
    issue_rob_index     = '0;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
    issue_rank          = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_idx           = IDX_W'(i);
        issue_alu_control   = ent_q[i].op.alu_control;
        issue_alu_src       = ent_q[i].op.alu_src;
        issue_is_for_lsq    = ent_q[i].op.is_for_lsq;
        issue_imm           = ent_q[i].op.imm;
        issue_rs1_value     = ent_q[i].rs1_value;
        issue_rs2_value     = ent_q[i].rs2_value;
        issue_tag_to_output = ent_q[i].dest_tag;
        issue_rob_index     = ent_q[i].rob_index;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
        issue_rank          = rank_q[i];
`endif
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--)
      if (!ent_q[i-1].valid) free_idx = IDX_W'(i - 1);
  end

  always_comb begin
    rs1_match              = wakeup_active && (disp_rs1_tag == wakeup_tag);
    rs2_match              = wakeup_active && (disp_rs2_tag == wakeup_tag);
    disp_ent               = '0;
    disp_ent.valid         = 1'b1;
    disp_ent.op.alu_control = disp_alu_control;
    disp_ent.op.alu_src    = disp_alu_src;
    disp_ent.op.is_for_lsq = disp_is_for_lsq;
    disp_ent.op.imm        = disp_imm;
    disp_ent.rs1_ready     = disp_rs1_ready || rs1_match;
    disp_ent.rs1_tag       = disp_rs1_tag;
    disp_ent.rs1_value     = (!disp_rs1_ready && rs1_match) ? wakeup_value : disp_rs1_value;
    disp_ent.rs2_ready     = disp_rs2_ready || rs2_match;
    disp_ent.rs2_tag       = disp_rs2_tag;
    disp_ent.rs2_value     = (!disp_rs2_ready && rs2_match) ? wakeup_value : disp_rs2_value;
    disp_ent.dest_tag      = disp_dest_tag;
    disp_ent.rob_index     = disp_rob_index;
  end

  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
    rank_d = rank_q;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wakeup_active && ent_q[i].valid) begin
        if (!ent_q[i].rs1_ready && ent_q[i].rs1_tag == wakeup_tag) begin
          ent_d[i].rs1_ready = 1'b1;
          ent_d[i].rs1_value = wakeup_value;
        end
        if (!ent_q[i].rs2_ready && ent_q[i].rs2_tag == wakeup_tag) begin
          ent_d[i].rs2_ready = 1'b1;
          ent_d[i].rs2_value = wakeup_value;
        end
      end
    end
    if (issue_fire) begin
      ent_d[issue_idx].valid = 1'b0;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
      for (int unsigned i = 0; i < DEPTH; i++)
        if (rank_q[i] > issue_rank) rank_d[i] = rank_q[i] - 1'b1;
`endif
    end
    if (disp_fire) begin
      ent_d[free_idx] = disp_ent;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
      // Youngest rank counts entries left after this cycle's issue.
      rank_d[free_idx] = IDX_W'(occ_q - OCC_W'(issue_fire));
`endif
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q  <= '0;
      occ_q  <= '0;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
      rank_q <= '0;
`endif
    end else begin
      ent_q  <= ent_d;
      occ_q  <= occ_d;
`ifdef RESERVATION_STATION_OLDEST_FIRST_EN
      rank_q <= rank_d;
`endif
    end
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

ALU reservation station sitting directly upstream of the ALU functional unit. It buffers dispatched operations until both source operands are available, snoops the wakeup bus to capture operand values, and issues one ready operation per cycle into the FU when the FU reports availability. Issue fields map 1:1 onto the FU dispatch interface.

## Interface
- DEPTH, 8, number of entries (power of two, 2..16)
- TAG_W, 6, physical tag width
- ROB_W, 6, ROB index width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_alu_control  in  4  ALU operation code
- disp_alu_src  in  1  0 = rs1 op rs2, 1 = rs1 op imm
- disp_is_for_lsq  in  1  result goes to LSQ address bus
- disp_imm  in  32  immediate
- disp_rs1_ready / disp_rs2_ready  in  1  operand already valid
- disp_rs1_tag / disp_rs2_tag  in  TAG_W  producer tag if not ready
- disp_rs1_value / disp_rs2_value  in  32  operand value if ready
- disp_dest_tag  in  TAG_W  destination tag
- disp_rob_index  in  ROB_W  ROB index
- wakeup_active  in  1  wakeup bus valid
- wakeup_tag  in  TAG_W  completing tag
- wakeup_value  in  32  completing value
- fu_is_available  in  1  FU can accept this cycle
- issue_write_enable  out  1  FU write strobe
- issue_alu_control, issue_alu_src, issue_is_for_lsq, issue_imm, issue_rs1_value, issue_rs2_value, issue_tag_to_output, issue_rob_index  out  as FU  issued fields
- occupancy  out  $clog2(DEPTH)+1  valid entry count

## Operation
- Entry: valid, op fields, per-operand ready/tag/value, age rank.
- Dispatch accepted when disp_valid && disp_ready; written to lowest-index free entry.
- Wakeup snoop: every valid entry operand with !ready && tag == wakeup_tag && wakeup_active captures value, sets ready.
- Dispatch-cycle capture: non-ready dispatched operand matching the current wakeup is stored ready with wakeup_value.
- Selection: entries with both operands ready (registered state); pick per Configuration.
- issue_write_enable = fu_is_available && any ready entry; selected entry freed on that edge.
- Age rank: new entry gets rank = occupancy after same-cycle issue; on issue, ranks above the issued rank decrement. Ranks always a permutation 0..occupancy-1.
- disp_valid while !disp_ready: request dropped, state unchanged.
- flush: all valid cleared next edge; dispatch and issue in that cycle discarded; issue_write_enable still reflects pre-flush state that cycle (FU must be flushed in parallel).
- Reset: all entries invalid; disp_ready=1, issue_write_enable=0, occupancy=0, all issue data outputs 0.

## Timing
- Issue outputs combinational from registered entry state; no wakeup-to-issue combinational path.
- Dispatch with both ready at cycle t → earliest issue cycle t+1.
- Wakeup at cycle t → dependent entry issuable at t+1.
- disp_ready = occupancy < DEPTH, registered-state based; no same-cycle freed-slot reuse.
- Simultaneous dispatch and issue allowed; occupancy unchanged.
- Throughput: one issue per cycle.

## Configuration
- RESERVATION_STATION_OLDEST_FIRST_EN defined: select ready entry with lowest age rank.
- Undefined: select lowest-index ready entry; age rank logic removed.

## Structure
- Shared package rs_pkg: entry struct typedef, ALU control code constants (NONE 0000, OR 0001, ADD 0010, XOR 0011, SRA 1011, PASS 1111), TAG_W/ROB_W defaults.
- Sub-module rs_select: ready vector + ranks in, one-hot grant and valid out.

## Test plan
- Reset release, dispatch ADD rs1=5 rs2=7 both ready, fu_is_available=1 → next cycle issue_write_enable=1, issue_alu_control=0010, rs1 5, rs2 7.
- Dispatch op waiting on tag 12; wakeup tag 12 value 0x99 at cycle t → issue at t+1 with rs1=0x99.
- Dispatch with rs2 tag 3 while wakeup tag 3 value 0x44 same cycle → entry captured ready, issues next cycle with rs2=0x44.
- Fill DEPTH entries with fu_is_available=0 → disp_ready=0, occupancy=DEPTH; extra dispatch dropped; raise availability → DEPTH issues in dispatch order (macro on).
- Ready entries in index 3 (older) and 1 (younger) → macro on issues index 3 first; macro off issues index 1 first.
- Flush with 4 valid entries and concurrent dispatch → occupancy=0 next cycle, no later issue.
